// File: rtl/br_pkg.sv
// Shared branch-resolution types: op codes, 2-bit counter encodings, resolver states.
// Optional BHT is enabled by defining BRANCH_BHT_EN.
package br_pkg;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_EQ   = 3'd1;
    localparam logic [2:0] BR_NE   = 3'd2;
    localparam logic [2:0] BR_LT   = 3'd3;
    localparam logic [2:0] BR_GE   = 3'd4;
    localparam logic [2:0] BR_LTU  = 3'd5;
    localparam logic [2:0] BR_GEU  = 3'd6;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        SQUASH
    } br_state_e;

    function automatic logic [1:0] cnt_update(input logic [1:0] cnt,
                                              input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken && cnt != ST) nxt = cnt + 2'd1;
        if (!taken && cnt != SNT) nxt = cnt - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// 2-bit saturating-counter branch history table.
// Combinational read returns the stored (pre-update) value; one write port.
module bht_2bit
    import br_pkg::*;
#(
    parameter int ENTRIES = 64,
    localparam int IDX = $clog2(ENTRIES)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [IDX-1:0] rd_idx,
    output logic [1:0]     rd_cnt,
    input  logic           wr_en,
    input  logic [IDX-1:0] wr_idx,
    input  logic           wr_taken
);

    logic [1:0] mem_q [ENTRIES];
    logic [1:0] mem_d [ENTRIES];

    assign rd_cnt = mem_q[rd_idx];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_idx] = cnt_update(mem_q[wr_idx], wr_taken);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) mem_q[i] <= WNT;
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: mispredict redirect/flush, wrong-path squash, BHT training.
// Define BRANCH_BHT_EN for a dynamic BHT; otherwise IF predicts static not-taken.
module branch_resolve_unit
    import br_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic [3:0]      ex_br_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX = $clog2(BHT_ENTRIES);

    br_state_e       state_q, state_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic            flush_q, flush_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0] op;
    logic       is_br;
    logic       squash;
    logic       resolve;
    logic       actual;
    logic       mispredict;

    assign op      = ex_br_taken[2:0];
    assign actual  = ex_br_taken[3];
    assign is_br   = op inside {BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU};
    // The slot seen while a redirect is in flight is wrong-path.
    assign squash  = (state_q == REDIRECT) || (state_q == SQUASH);
    assign resolve = ex_valid && !ex_stall && is_br && !squash;
    assign mispredict = resolve && (actual != ex_pred_taken);

`ifdef BRANCH_BHT_EN
    logic [1:0] bht_cnt;
    logic       unused_pc;

    bht_2bit #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (if_pc[IDX+1:2]),
        .rd_cnt   (bht_cnt),
        .wr_en    (resolve),
        .wr_idx   (ex_pc[IDX+1:2]),
        .wr_taken (actual)
    );

    assign if_pred_taken = bht_cnt[1];
    assign unused_pc = ^{if_pc[XLEN-1:IDX+2], if_pc[1:0]};
`else
    logic unused_pc;
    assign if_pred_taken = 1'b0;
    assign unused_pc = ^if_pc;
`endif

    always_comb begin
        state_d          = state_q;
        redirect_valid_d = mispredict;
        flush_d          = mispredict;
        redirect_pc_d    = redirect_pc_q;
        cnt_d            = cnt_q;
        if (mispredict) begin
            redirect_pc_d = actual ? ex_target : ex_pc + XLEN'(4);
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
        unique case (state_q)
            IDLE:     state_d = mispredict ? REDIRECT : IDLE;
            REDIRECT: state_d = ex_stall ? SQUASH : IDLE;
            SQUASH:   state_d = ex_stall ? SQUASH : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            redirect_pc_q    <= '0;
            cnt_q            <= '0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            flush_q          <= flush_d;
            redirect_pc_q    <= redirect_pc_d;
            cnt_q            <= cnt_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign flush          = flush_q;
    assign redirect_pc    = redirect_pc_q;
    assign mispred_cnt    = cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit (CNT_W=4 to reach saturation quickly).
// Works with or without BRANCH_BHT_EN.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_stall;
    logic [3:0]  ex_br_taken;
    logic [63:0] ex_pc;
    logic [63:0] ex_target;
    logic        ex_pred_taken;
    logic [63:0] if_pc;
    logic        if_pred_taken;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        flush;
    logic [3:0]  mispred_cnt;

    branch_resolve_unit #(
        .XLEN        (64),
        .BHT_ENTRIES (64),
        .CNT_W       (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_stall       (ex_stall),
        .ex_br_taken    (ex_br_taken),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rv;
        logic        fl;
        logic [63:0] pc;
        logic [3:0]  cnt;
    } exp_t;

    typedef struct packed {
        logic        v;
        logic        s;
        logic        tk;
        logic [2:0]  op;
        logic [63:0] pc;
        logic [63:0] tgt;
        logic        pred;
    } stim_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    logic        m_rv;
    logic        m_hold;
    logic [63:0] m_rpc;
    logic [3:0]  m_cnt;
    logic [1:0]  m_bht [64];

    function automatic logic m_pred(input logic [63:0] pc);
`ifdef BRANCH_BHT_EN
        return m_bht[pc[7:2]][1];
`else
        return 1'b0;
`endif
    endfunction

    // Drive one cycle, advance the reference model and queue what must appear after the edge.
    task automatic drive(input logic r, input stim_t st);
        logic sq, res, mis;
        rst = r;
        ex_valid = st.v;
        ex_stall = st.s;
        ex_br_taken = {st.tk, st.op};
        ex_pc = st.pc;
        ex_target = st.tgt;
        ex_pred_taken = st.pred;
        if (r) begin
            m_rv = 1'b0;
            m_hold = 1'b0;
            m_rpc = '0;
            m_cnt = '0;
            for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
        end else begin
            sq  = m_rv || m_hold;
            res = st.v && !st.s && st.op >= 3'd1 && st.op <= 3'd6 && !sq;
            mis = res && (st.tk != st.pred);
            m_hold = sq && st.s;
            if (mis) begin
                m_rpc = st.tk ? st.tgt : st.pc + 64'd4;
                if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
            end
            if (res) begin
                if (st.tk && m_bht[st.pc[7:2]] != 2'd3)
                    m_bht[st.pc[7:2]] = m_bht[st.pc[7:2]] + 2'd1;
                if (!st.tk && m_bht[st.pc[7:2]] != 2'd0)
                    m_bht[st.pc[7:2]] = m_bht[st.pc[7:2]] - 2'd1;
            end
            m_rv = mis;
        end
        sb.push_back('{m_rv, m_rv, m_rpc, m_cnt});
        @(posedge clk);
        #1;
    endtask

    localparam stim_t IDLE_S = '{1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0};

    task automatic test_reset();
        exp_t e;
        drive(1'b1, IDLE_S);
        e = sb.pop_front();
        n_chk++;
        if ({redirect_valid, flush, redirect_pc, mispred_cnt} !== e)
            $display("FAIL reset: got rv=%b fl=%b pc=%h cnt=%h, exp rv=%b fl=%b pc=%h cnt=%h",
                     redirect_valid, flush, redirect_pc, mispred_cnt, e.rv, e.fl, e.pc, e.cnt);
        else n_pass++;
        if_pc = 64'h40;
        #1;
        n_chk++;
        if (if_pred_taken !== 1'b0)
            $display("FAIL reset_pred: got %b exp 0", if_pred_taken);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_mispredict();
        exp_t  e;
        stim_t tbl [7];
        tbl = '{
            '{1'b1, 1'b0, 1'b1, 3'd1, 64'h100, 64'h180, 1'b0},
            IDLE_S,
            '{1'b1, 1'b0, 1'b0, 3'd2, 64'h200, 64'h280, 1'b1},
            '{1'b1, 1'b0, 1'b1, 3'd1, 64'h300, 64'h380, 1'b0},
            IDLE_S,
            '{1'b1, 1'b0, 1'b0, 3'd5, 64'hFFFF_FFFF_FFFF_FFFC, 64'h10, 1'b1},
            '{1'b1, 1'b0, 1'b1, 3'd4, 64'h600, 64'h640, 1'b1}
        };
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, tbl[i]);
            e = sb.pop_front();
            n_chk++;
            if ({redirect_valid, flush, redirect_pc, mispred_cnt} !== e)
                $display("FAIL mispredict[%0d]: got rv=%b fl=%b pc=%h cnt=%h, exp rv=%b fl=%b pc=%h cnt=%h",
                         i, redirect_valid, flush, redirect_pc, mispred_cnt, e.rv, e.fl, e.pc, e.cnt);
            else n_pass++;
        end
    endtask

    task automatic test_nonbranch();
        exp_t  e;
        stim_t tbl [3];
        logic  p0;
        if_pc = 64'h40;
        #1;
        p0 = m_pred(64'h40);
        tbl = '{
            '{1'b1, 1'b0, 1'b1, 3'd0, 64'h40, 64'h400, 1'b0},
            '{1'b1, 1'b0, 1'b1, 3'd7, 64'h40, 64'h400, 1'b0},
            '{1'b1, 1'b0, 1'b1, 3'd7, 64'h40, 64'h400, 1'b0}
        };
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, tbl[i]);
            e = sb.pop_front();
            n_chk++;
            if ({redirect_valid, flush, redirect_pc, mispred_cnt} !== e)
                $display("FAIL nonbranch[%0d]: got rv=%b fl=%b pc=%h cnt=%h, exp rv=%b fl=%b pc=%h cnt=%h",
                         i, redirect_valid, flush, redirect_pc, mispred_cnt, e.rv, e.fl, e.pc, e.cnt);
            else n_pass++;
        end
        n_chk++;
        if (if_pred_taken !== p0)
            $display("FAIL nonbranch_bht: got %b exp %b", if_pred_taken, p0);
        else n_pass++;
    endtask

    task automatic test_bht();
        exp_t  e;
        stim_t st;
        logic  p;
        drive(1'b1, IDLE_S);
        void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            if_pc = 64'h40;
            #1;
            p = m_pred(64'h40);
            n_chk++;
            if (if_pred_taken !== p)
                $display("FAIL bht_pred[%0d]: got %b exp %b", i, if_pred_taken, p);
            else n_pass++;
            st = '{1'b1, 1'b0, (i < 3), 3'd1, 64'h40, 64'h80, p};
            drive(1'b0, st);
            e = sb.pop_front();
            n_chk++;
            if ({redirect_valid, flush, redirect_pc, mispred_cnt} !== e)
                $display("FAIL bht_res[%0d]: got rv=%b fl=%b pc=%h cnt=%h, exp rv=%b fl=%b pc=%h cnt=%h",
                         i, redirect_valid, flush, redirect_pc, mispred_cnt, e.rv, e.fl, e.pc, e.cnt);
            else n_pass++;
            drive(1'b0, IDLE_S);
            void'(sb.pop_front());
        end
        #1;
        n_chk++;
        if (if_pred_taken !== 1'b0)
            $display("FAIL bht_final: got %b exp 0", if_pred_taken);
        else n_pass++;
    endtask

    task automatic test_stall();
        exp_t  e;
        stim_t tbl [6];
        tbl = '{
            '{1'b1, 1'b1, 1'b1, 3'd3, 64'h300, 64'h340, 1'b0},
            '{1'b1, 1'b0, 1'b1, 3'd3, 64'h300, 64'h340, 1'b0},
            '{1'b1, 1'b1, 1'b1, 3'd1, 64'h500, 64'h540, 1'b0},
            '{1'b1, 1'b0, 1'b1, 3'd1, 64'h500, 64'h540, 1'b0},
            '{1'b1, 1'b0, 1'b1, 3'd1, 64'h500, 64'h540, 1'b0},
            IDLE_S
        };
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, tbl[i]);
            e = sb.pop_front();
            n_chk++;
            if ({redirect_valid, flush, redirect_pc, mispred_cnt} !== e)
                $display("FAIL stall[%0d]: got rv=%b fl=%b pc=%h cnt=%h, exp rv=%b fl=%b pc=%h cnt=%h",
                         i, redirect_valid, flush, redirect_pc, mispred_cnt, e.rv, e.fl, e.pc, e.cnt);
            else n_pass++;
        end
    endtask

    task automatic test_saturate();
        exp_t  e;
        stim_t st;
        for (int i = 0; i < 20; i++) begin
            st = '{1'b1, 1'b0, 1'b0, 3'd2, 64'(i * 8), 64'h900, 1'b1};
            drive(1'b0, st);
            e = sb.pop_front();
            n_chk++;
            if ({redirect_valid, flush, redirect_pc, mispred_cnt} !== e)
                $display("FAIL saturate[%0d]: got rv=%b fl=%b pc=%h cnt=%h, exp rv=%b fl=%b pc=%h cnt=%h",
                         i, redirect_valid, flush, redirect_pc, mispred_cnt, e.rv, e.fl, e.pc, e.cnt);
            else n_pass++;
            drive(1'b0, IDLE_S);
            void'(sb.pop_front());
        end
        n_chk++;
        if (mispred_cnt !== 4'hF)
            $display("FAIL saturate_cnt: got %h exp f", mispred_cnt);
        else n_pass++;
        st = '{1'b1, 1'b0, 1'b1, 3'd6, 64'hA00, 64'hA80, 1'b0};
        drive(1'b0, st);
        void'(sb.pop_front());
        drive(1'b1, IDLE_S);
        e = sb.pop_front();
        n_chk++;
        if ({redirect_valid, flush, redirect_pc, mispred_cnt} !== e)
            $display("FAIL reset_in_redirect: got rv=%b fl=%b pc=%h cnt=%h, exp rv=%b fl=%b pc=%h cnt=%h",
                     redirect_valid, flush, redirect_pc, mispred_cnt, e.rv, e.fl, e.pc, e.cnt);
        else n_pass++;
        drive(1'b0, IDLE_S);
        e = sb.pop_front();
        n_chk++;
        if ({redirect_valid, flush, redirect_pc, mispred_cnt} !== e)
            $display("FAIL after_reset: got rv=%b fl=%b pc=%h cnt=%h, exp rv=%b fl=%b pc=%h cnt=%h",
                     redirect_valid, flush, redirect_pc, mispred_cnt, e.rv, e.fl, e.pc, e.cnt);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        ex_valid = 1'b0;
        ex_stall = 1'b0;
        ex_br_taken = '0;
        ex_pc = '0;
        ex_target = '0;
        ex_pred_taken = 1'b0;
        if_pc = '0;
        #1;
        test_reset();
        test_mispredict();
        test_nonbranch();
        test_bht();
        test_stall();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
